// File: rtl/rsa_mult_pkg.sv
// Shared types and helpers for the 64x64 sequential multiplier built on a
// single 32x32 registered hard multiplier.
package rsa_mult_pkg;

    localparam int HALF_W = 32;
    localparam int FULL_W = 64;
    localparam int PROD_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Partial-product index: {a half, b half} -> 0:lo*lo 1:lo*hi 2:hi*lo 3:hi*hi
    typedef logic [1:0] pp_idx_t;

    // Left shift applied to a returned partial product before accumulation.
    function automatic logic [6:0] pp_shift(input pp_idx_t idx);
        logic [6:0] sh;
        case (idx)
            2'd0:    sh = 7'd0;
            2'd1:    sh = 7'd32;
            2'd2:    sh = 7'd32;
            2'd3:    sh = 7'd64;
            default: sh = 7'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// Delay line that carries {valid, index} alongside the operands through the
// hard multiplier so each returned product can be matched to its shift.
module mult_tag_pipe
    import rsa_mult_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    in_vld,
    input  pp_idx_t in_idx,
    output logic    out_vld,
    output pp_idx_t out_idx
);

    logic [LAT-1:0]      vld_q, vld_d;
    logic [LAT-1:0][1:0] idx_q, idx_d;

    // Shift every stage one step; the new tag enters stage 0.
    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = in_vld;
        idx_d[0] = in_idx;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // Stage registers; reset empties the pipe so nothing stale is accumulated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q[LAT-1];
    assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/mult64_seq.sv
// 64x64 unsigned multiply sequenced through one 32x32 registered multiplier:
// four partial products issued back-to-back, returned products accumulated
// with the shift carried by the tag pipe.
module mult64_seq
    import rsa_mult_pkg::*;
#(
    parameter int MULT_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FULL_W-1:0]    in_a,
    input  logic [FULL_W-1:0]    in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PROD_W-1:0]    out_p,
    output logic                 busy,
    output logic [HALF_W-1:0]    mult_a,
    output logic [HALF_W-1:0]    mult_b,
    output logic                 mult_ce,
    input  logic [2*HALF_W-1:0]  mult_dout
);

    state_e              state_q, state_d;
    pp_idx_t             idx_q, idx_d;
    logic [FULL_W-1:0]   a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d, out_p_q, out_p_d;
    logic [HALF_W-1:0]   mult_a_q, mult_a_d, mult_b_q, mult_b_d;
    logic                mult_ce_q, mult_ce_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    pp_idx_t             nxt_idx_s;
    logic                tag_in_vld_s;
    logic                tag_out_vld_s;
    pp_idx_t             tag_out_idx_s;
    logic [PROD_W-1:0]   pp_ext_s;

    // The tag travels with the operand pair currently on mult_a/mult_b.
    assign tag_in_vld_s = (state_q == ST_ISSUE);

    mult_tag_pipe #(
        .LAT (MULT_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (tag_in_vld_s),
        .in_idx  (idx_q),
        .out_vld (tag_out_vld_s),
        .out_idx (tag_out_idx_s)
    );

    // Next-state, operand issue, accumulation and registered-output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        out_p_d     = out_p_q;
        mult_a_d    = mult_a_q;
        mult_b_d    = mult_b_q;
        out_valid_d = out_valid_q;
        nxt_idx_s   = idx_q + 2'd1;
        pp_ext_s    = {{(PROD_W-2*HALF_W){1'b0}}, mult_dout} << pp_shift(tag_out_idx_s);

        // Products only count when a valid tag exits with them.
        if (tag_out_vld_s) begin
            acc_d = acc_q + pp_ext_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    acc_d    = '0;
                    idx_d    = 2'd0;
                    mult_a_d = in_a[HALF_W-1:0];
                    mult_b_d = in_b[HALF_W-1:0];
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (idx_q == 2'd3) begin
                    // Last pair stays on the multiplier inputs while draining.
                    state_d = ST_DRAIN;
                end else begin
                    idx_d    = nxt_idx_s;
                    mult_a_d = nxt_idx_s[1] ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
                    mult_b_d = nxt_idx_s[0] ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (tag_out_vld_s && (tag_out_idx_s == 2'd3)) begin
                    out_p_d     = acc_d;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d     = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mult_ce_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_p_q     <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            mult_ce_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            out_p_q     <= out_p_d;
            mult_a_q    <= mult_a_d;
            mult_b_q    <= mult_b_d;
            mult_ce_q   <= mult_ce_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign mult_ce   = mult_ce_q;

endmodule

// File: tb/tb_mult64_seq.sv
// Self-checking bench for mult64_seq with a behavioural 2-stage registered
// 32x32 multiplier standing in for the hard macro (never reset).
module tb_mult64_seq;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_p;
    logic         busy;
    logic [31:0]  mult_a;
    logic [31:0]  mult_b;
    logic         mult_ce;
    logic [63:0]  mult_dout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    // Multiplier model: input register then output register, gated by ce.
    logic [31:0] g_a_r  = 32'hDEAD_BEEF;
    logic [31:0] g_b_r  = 32'hCAFE_F00D;
    logic [63:0] g_dout = 64'hA5A5_5A5A_1234_5678;

    mult64_seq #(.MULT_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_ce   (mult_ce),
        .mult_dout (mult_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mult_ce) begin
            g_a_r  <= mult_a;
            g_b_r  <= mult_b;
            g_dout <= {32'd0, g_a_r} * {32'd0, g_b_r};
        end
    end
    assign mult_dout = g_dout;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".in_ready"},  128'(in_ready),  128'd0);
        check({name, ".out_valid"}, 128'(out_valid), 128'd0);
        check({name, ".out_p"},     out_p,           128'd0);
        check({name, ".busy"},      128'(busy),      128'd0);
        check({name, ".mult_a"},    128'(mult_a),    128'd0);
        check({name, ".mult_b"},    128'(mult_b),    128'd0);
        check({name, ".mult_ce"},   128'(mult_ce),   128'd0);
    endtask

    // Wait (bounded) for in_ready, return at the negedge just after the accept edge.
    task automatic accept_op(input logic [63:0] a, input logic [63:0] b, input string name,
                             output bit ok, output int acc_cyc);
        int w;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) begin
            check({name, ".accept_timeout"}, 128'(in_ready), 128'd1);
        end else begin
            @(negedge clk);
        end
        acc_cyc = cyc_cnt;
    endtask

    // Full operation with out_ready high: checks latency and product.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp,
                          input string name, output int acc_cyc);
        bit ok;
        bit got;
        accept_op(a, b, name, ok, acc_cyc);
        in_valid = 1'b0;
        got = 1'b0;
        if (ok) begin
            for (int n = 1; n <= 30 && !got; n++) begin
                if (out_valid === 1'b1) begin
                    got = 1'b1;
                    check({name, ".latency"}, 128'(n), 128'd7);
                    check({name, ".out_p"}, out_p, exp);
                end else begin
                    @(negedge clk);
                end
            end
            if (!got) begin
                check({name, ".out_valid_timeout"}, 128'(out_valid), 128'd1);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_c;
        int  prev_c;
        int  hs_c;
        bit  ok;
        logic [63:0] ra;
        logic [63:0] rb;

        vecs[0] = '{64'd1, 64'd1, 128'd1};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2] = '{64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000,
                    128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[3] = '{64'h0000_0001_0000_0000, 64'd1, 128'h0000_0001_0000_0000};
        vecs[4] = '{64'd1, 64'h0000_0001_0000_0000, 128'h0000_0001_0000_0000};
        vecs[5] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
        vecs[6] = '{64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd2, 128'h0000_0000_0000_0001_0000_0000_0000_0000};
        vecs[8] = '{64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
                    128'h0000_0000_0000_0001_0000_0002_0000_0001};
        vecs[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 64'd0;
        in_b      = 64'd0;
        out_ready = 1'b1;

        // Reset state and in_ready release timing.
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        #1;
        check("release.in_ready_low", 128'(in_ready), 128'd0);
        @(negedge clk);
        check("release.in_ready_high", 128'(in_ready), 128'd1);

        // 1*1 with cycle-by-cycle ce / out_valid timing.
        accept_op(64'd1, 64'd1, "t1", ok, acc_c);
        in_valid = 1'b0;
        if (ok) begin
            for (int n = 1; n <= 7; n++) begin
                check($sformatf("t1.ce_c%0d", n), 128'(mult_ce), (n <= 6) ? 128'd1 : 128'd0);
                check($sformatf("t1.busy_c%0d", n), 128'(busy), 128'd1);
                check($sformatf("t1.ov_c%0d", n), 128'(out_valid), (n == 7) ? 128'd1 : 128'd0);
                if (n == 7) check("t1.out_p", out_p, 128'd1);
                @(negedge clk);
            end
            check("t1.after.out_valid", 128'(out_valid), 128'd0);
            check("t1.after.in_ready", 128'(in_ready), 128'd1);
            check("t1.after.busy", 128'(busy), 128'd0);
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i), acc_c);
        end

        // Backpressure in DONE with a new pair waiting.
        out_ready = 1'b0;
        accept_op(64'd7, 64'd9, "bp", ok, acc_c);
        in_a = 64'd11;
        in_b = 64'd13;
        for (int w = 0; w < 20 && out_valid !== 1'b1; w++) @(negedge clk);
        check("bp.out_valid", 128'(out_valid), 128'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp.out_p_%0d", k), out_p, 128'd63);
            check($sformatf("bp.out_valid_%0d", k), 128'(out_valid), 128'd1);
            check($sformatf("bp.in_ready_%0d", k), 128'(in_ready), 128'd0);
            check($sformatf("bp.mult_ce_%0d", k), 128'(mult_ce), 128'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        hs_c = cyc_cnt;
        @(negedge clk);
        check("bp.hs.out_valid", 128'(out_valid), 128'd0);
        check("bp.hs.in_ready", 128'(in_ready), 128'd1);
        run_op(64'd11, 64'd13, 128'd143, "bp_next", acc_c);
        check("bp.accept_gap", 128'(acc_c - hs_c), 128'd2);

        // Asynchronous reset in the middle of an operation.
        accept_op(64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978, "rst", ok, acc_c);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready_low", 128'(in_ready), 128'd0);
        @(negedge clk);
        check("rst.in_ready_high", 128'(in_ready), 128'd1);
        run_op(64'd3, 64'd5, 128'd15, "after_rst", acc_c);

        // Random back-to-back operations against a 128-bit reference product.
        prev_c = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            run_op(ra, rb, {64'd0, ra} * {64'd0, rb}, $sformatf("rnd%0d", i), acc_c);
            if (i > 0) check($sformatf("rnd%0d.period", i), 128'(acc_c - prev_c), 128'd8);
            prev_c = acc_c;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult64_seq.md
Name: mult64_seq

Overview:
Sequencer that computes a 64x64 unsigned product using the single 32x32 registered hard multiplier, Gowin_MULT, in the RSA datapath. It splits the operands into four 32-bit partial products and issues them back-to-back into the multiplier. Returned products are tracked by a tag pipeline and accumulated with the correct shifts. The block sits between the modular-arithmetic engine (valid/ready requester) and the Gowin_MULT instance, which it drives directly.

Parameters:
MULT_LAT, 2, cycles from operands presented on mult_a/mult_b (with mult_ce=1) to the product valid on mult_dout; 2 matches AREG+OUT0_REG, PIPE_REG off
HALF_W, 32, partial operand width; fixed by the multiplier macro, not to be overridden

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  64  multiplicand, unsigned
in_b  in  64  multiplier, unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_p  out  128  product in_a*in_b
busy  out  1  high in any state other than IDLE
mult_a  out  32  to Gowin_MULT a
mult_b  out  32  to Gowin_MULT b
mult_ce  out  1  to Gowin_MULT ce
mult_dout  in  64  from Gowin_MULT dout

Behaviour:
- Reset (async, any state) clears the following to 0: state=IDLE, in_ready=0 until first clk edge after release, out_valid, out_p, busy, mult_a, mult_b, mult_ce, accumulator, operand regs, tag pipe.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch a and b, clear the accumulator, issue index=0, and go to ISSUE.
- ISSUE: lasts exactly 4 cycles, one partial product per cycle, in this order:
  - idx0: a_lo*b_lo, shift 0
  - idx1: a_lo*b_hi, shift 32
  - idx2: a_hi*b_lo, shift 32
  - idx3: a_hi*b_hi, shift 64
  - mult_a/mult_b are registered, and a valid tag is pushed into the tag pipe the same cycle.
  - After idx3, go to DRAIN.
- DRAIN: mult_a/mult_b hold their last value. Stay until the idx3 tag exits the tag pipe, then go to DONE.
- mult_ce=1 throughout ISSUE and DRAIN, and 0 in IDLE and DONE. ce never drops while a tag is in flight.
- Tag pipe: MULT_LAT-deep shift of {valid, idx[1:0]}, aligned so the tag exits in the cycle mult_dout carries that product. On an exiting valid tag: acc <= acc + (mult_dout << shift(idx)). Width is 128 bits, the add is full-width, and no overflow is possible.
- DONE: out_valid=1 and out_p=acc. Both are held stable until out_ready. On handshake, clear out_valid and return to IDLE.
- in_ready=0 outside IDLE. There is no overlap between operations.
- Timing: accept edge is cycle 0. Operands are presented in cycles 1-4, products arrive in cycles 1+MULT_LAT through 4+MULT_LAT, and out_valid rises in cycle 5+MULT_LAT (cycle 7 for default).
- Throughput: with out_ready held high, one result every 6+MULT_LAT cycles (8 for default).
- mult_dout is ignored whenever no valid tag exits. Stale products left in Gowin_MULT registers after reset or idle are never accumulated.
- Multiplier reset is tied off by the top level. The tag pipe alone guarantees correctness.
- in_valid deasserting mid-operation is don't-care. Operands are already latched.

Decomposition:
- Package rsa_mult_pkg holds:
  - the state enum
  - HALF_W=32, FULL_W=64, PROD_W=128
  - the partial-product index typedef (2 bits)
  - a shift-amount function of the index: 0, 32, 32, 64
- One sub-module, mult_tag_pipe: parameterised MULT_LAT-deep valid/idx delay line with async reset. The top module holds the FSM, operand regs and accumulator.

Test Plan:
1. a=1, b=1, out_ready=1 -> out_valid in cycle 7 after accept, out_p=1, mult_ce high in cycles 1-6 only.
2. a=b=0xFFFF_FFFF_FFFF_FFFF -> out_p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
3. a=b=0x0000_0001_0000_0000 -> out_p=0x0000_0000_0000_0001_0000_0000_0000_0000 (only idx3 nonzero, shift 64 verified).
4. Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with a new pair -> out_p stable, in_ready=0, mult_ce=0. The new pair is accepted the cycle after the out handshake.
5. Reset asserted in cycle 3 of an operation, released 2 cycles later -> all outputs 0 immediately (async). A following op a=3, b=5 returns out_p=15 with no stale product contribution, even though Gowin_MULT holds old data.
6. 1000 random back-to-back pairs with out_ready=1 vs a 128-bit reference model -> all match, accept-to-accept period exactly 8 cycles.
